// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared op/state types, job record and constants for fpu_job_sequencer
package fpu_seq_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB, OP_MUL, OP_DIV} op_e;
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3, S_CLEAR = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE, ST_ISSUE = S_ISSUE, ST_WAIT = S_WAIT, ST_RESP = S_RESP, ST_CLEAR = S_CLEAR
  } state_e;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_TMO = 2;
  // Widest tag a job record can carry; narrower TAG_W values are zero-extended into it
  localparam int TAG_MAX_W = 16;
  typedef struct packed {
    op_e                  op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [TAG_MAX_W-1:0] tag;
  } job_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/fpu_seq_fifo.sv
// fpu_seq_fifo: DEPTH-entry job FIFO with full/empty flags and occupancy count
module fpu_seq_fifo
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  job_t                         din_i,
  output job_t                         dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  job_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;
  logic wr, rd;
  assign full_o  = lvl_q == LW'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];
  assign level_o = lvl_q;
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wp_q] <= din_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(wr);
      rp_q  <= rp_q + AW'(rd);
      lvl_q <= lvl_q + LW'(wr) - LW'(rd);
    end
  end
endmodule

// File: rtl/fpu_job_sequencer.sv
// fpu_job_sequencer: FIFO-buffered, one-job-at-a-time front-end for the floating_point_unit core.
// Optional FPU_SEQ_STATS_EN adds saturating job/overflow/underflow/timeout counters.
module fpu_job_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_op_i,
  input  logic [31:0]                req_a_i,
  input  logic [31:0]                req_b_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic                       fpu_start_o,
  output logic                       fpu_rst_o,
  output logic [1:0]                 fpu_op_o,
  output logic [31:0]                fpu_a_o,
  output logic [31:0]                fpu_b_o,
  input  logic [31:0]                fpu_z_i,
  input  logic                       fpu_overflow_i,
  input  logic                       fpu_underflow_i,
  input  logic                       fpu_busy_i,
  input  logic                       fpu_done_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_z_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [2:0]                 rsp_flags_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       idle_o
`ifdef FPU_SEQ_STATS_EN
  ,
  output logic [15:0]                stat_jobs_o,
  output logic [15:0]                stat_ovf_o,
  output logic [15:0]                stat_unf_o,
  output logic [15:0]                stat_tmo_o
`endif
);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam int LW = $clog2(DEPTH+1);
  job_t din, head;
  logic full, empty, push, pop;
  logic [LW-1:0] lvl_nxt;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d, rtag_q, rtag_d;
  logic [1:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [2:0] flg_q, flg_d;
  logic start_q, start_d, frst_q, frst_d, vld_q, vld_d, idle_q, idle_d;
  assign din  = '{op: op_e'(req_op_i), a: req_a_i, b: req_b_i, tag: TAG_MAX_W'(req_tag_i)};
  assign push = req_valid_i && !full;
  assign pop  = state_q == ST_ISSUE;
  fpu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push), .pop_i(pop), .din_i(din),
    .dout_o(head), .full_o(full), .empty_o(empty), .level_o(level_o)
  );
  // idle is registered, so it is derived from next-cycle occupancy and state
  assign lvl_nxt = level_o + LW'(push) - LW'(pop);
  assign idle_d  = state_d == ST_IDLE && lvl_nxt == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    start_d = start_q;
    frst_d  = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = vld_q;
    z_d     = z_q;
    rtag_d  = rtag_q;
    flg_d   = flg_q;
    case (state_q)
      ST_IDLE: state_d = empty ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: begin
        op_d    = head.op;
        a_d     = head.a;
        b_d     = head.b;
        tag_d   = TAG_W'(head.tag);
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        start_d = start_q && !(fpu_busy_i || fpu_done_i);
        // done wins over a simultaneous timeout
        if (fpu_done_i || cnt_d == CW'(TIMEOUT)) begin
          start_d = 1'b0;
          vld_d   = 1'b1;
          rtag_d  = tag_q;
          z_d     = fpu_done_i ? fpu_z_i : QNAN;
          flg_d   = fpu_done_i ? {1'b0, fpu_underflow_i, fpu_overflow_i} : 3'b1 << FLG_TMO;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready_i) begin
        vld_d   = 1'b0;
        frst_d  = 1'b1;
        state_d = ST_CLEAR;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      start_q <= 1'b0;
      frst_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      z_q     <= '0;
      rtag_q  <= '0;
      flg_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      start_q <= start_d;
      frst_q  <= frst_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      z_q     <= z_d;
      rtag_q  <= rtag_d;
      flg_q   <= flg_d;
      idle_q  <= idle_d;
    end
  end
  assign req_ready_o = !full;
  assign fpu_start_o = start_q;
  assign fpu_rst_o   = frst_q;
  assign fpu_op_o    = op_q;
  assign fpu_a_o     = a_q;
  assign fpu_b_o     = b_q;
  assign rsp_valid_o = vld_q;
  assign rsp_z_o     = z_q;
  assign rsp_tag_o   = rtag_q;
  assign rsp_flags_o = flg_q;
  assign idle_o      = idle_q;
`ifdef FPU_SEQ_STATS_EN
  logic [15:0] jobs_q, ovf_q, unf_q, tmo_q;
  logic hs;
  assign hs = state_q == ST_RESP && rsp_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jobs_q <= '0;
      ovf_q  <= '0;
      unf_q  <= '0;
      tmo_q  <= '0;
    end else begin
      jobs_q <= sat_inc(jobs_q, hs);
      ovf_q  <= sat_inc(ovf_q, hs && flg_q[FLG_OVF]);
      unf_q  <= sat_inc(unf_q, hs && flg_q[FLG_UNF]);
      tmo_q  <= sat_inc(tmo_q, hs && flg_q[FLG_TMO]);
    end
  end
  assign stat_jobs_o = jobs_q;
  assign stat_ovf_o  = ovf_q;
  assign stat_unf_o  = unf_q;
  assign stat_tmo_o  = tmo_q;
`endif
endmodule

// File: doc/fpu_job_sequencer.md
Name: fpu_job_sequencer

Overview:
Parametrised command front-end for the floating_point_unit start/busy/done core. It buffers tagged operation requests in a DEPTH-entry FIFO and issues them one at a time to the FPU. It captures the result and overflow/underflow flags, returns them on a valid/ready response port, and pulses the FPU reset between jobs. A watchdog terminates jobs whose done never arrives. It sits between any requester (CPU shim, bench driver) and floating_point_unit.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, >=2
TAG_W, 4, width of the requester tag carried with each job
TIMEOUT, 255, max cycles in WAIT before forced completion; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (= !full)
req_op  in  2  00 add, 01 sub, 10 mul, 11 div
req_a  in  32  IEEE-754 single operand A
req_b  in  32  IEEE-754 single operand B
req_tag  in  TAG_W  requester tag
fpu_start  out  1  to FPU start
fpu_rst  out  1  to FPU rst (active-high)
fpu_op  out  2  to FPU operation
fpu_a  out  32  to FPU input_a
fpu_b  out  32  to FPU input_b
fpu_z  in  32  FPU output_z
fpu_overflow  in  1  FPU overflow
fpu_underflow  in  1  FPU underflow
fpu_busy  in  1  FPU busy
fpu_done  in  1  FPU output_done
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts
rsp_z  out  32  result
rsp_tag  out  TAG_W  tag of the job
rsp_flags  out  3  {timeout, underflow, overflow}
level  out  $clog2(DEPTH+1)  FIFO occupancy
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (rst low, async): FIFO emptied, level=0, FSM=IDLE, fpu_start=0, fpu_rst=1, fpu_op/a/b=0, rsp_valid=0, rsp_z/tag/flags=0, idle=1, timeout counter=0. All outputs are registered.
- Push: a request is accepted when req_valid && req_ready. req_ready is low when full; there is no bypass. A push while full is not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle when neither full nor empty: level is unchanged.
- FSM states IDLE, ISSUE, WAIT, RESP, CLEAR:
  - IDLE: fpu_rst=0. If FIFO is non-empty, go to ISSUE.
  - ISSUE (1 cycle): pop the head into fpu_op/a/b and an internal tag register. Set fpu_start=1, clear the timeout counter, go to WAIT.
  - WAIT: fpu_start stays 1 until the first cycle where fpu_busy or fpu_done is seen, then drops to 0. The counter increments each cycle.
    - On fpu_done: rsp_z=fpu_z, rsp_flags={0, fpu_underflow, fpu_overflow}, rsp_valid=1, go to RESP.
    - Else, when the counter reaches TIMEOUT: rsp_z=32'h7FC00000, rsp_flags=3'b100, rsp_valid=1, go to RESP.
    - fpu_done takes priority over timeout in the same cycle.
  - RESP: rsp_* held stable while rsp_ready is low. On rsp_valid && rsp_ready: rsp_valid=0, fpu_rst=1, go to CLEAR.
  - CLEAR (1 cycle): fpu_rst=1 and fpu_start=0, go to IDLE (fpu_rst drops there).
- Minimum job overhead: ISSUE + CLEAR + IDLE = 3 cycles, plus FPU latency, plus response wait.
- Jobs complete strictly in FIFO order; only one job is in flight.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. level counts 0..DEPTH.
- Reset mid-job: the job is discarded with no response, and the FPU is held in reset while rst is low.

Optional Feature:
FPU_SEQ_STATS_EN:
- When defined, adds outputs stat_jobs, stat_ovf, stat_unf, stat_tmo (16 bits each).
- These are saturating counters incremented on each RESP handshake: every job, and per set flag bit respectively. They clear on reset.
- When undefined, the ports and logic are absent.

Decomposition:
- Package fpu_seq_pkg holds:
  - op enum (OP_ADD=2'b00, OP_SUB, OP_MUL, OP_DIV)
  - state enum
  - QNAN constant 32'h7FC00000
  - flag bit indices (FLG_OVF=0, FLG_UNF=1, FLG_TMO=2)
  - job struct {op, a, b, tag}
- One sub-module, fpu_seq_fifo: a synchronous DEPTH-entry FIFO of the job struct with full/empty/level.

Test Plan:
- ADD 3F800000+40000000, tag 3; FPU model asserts done 5 cycles after start with z=40400000 -> rsp_z=40400000, rsp_tag=3, rsp_flags=000; fpu_rst high exactly 1 cycle after the handshake.
- FPU held busy; push 5 requests with tags 0..4, DEPTH=4 -> the first job is popped, then tags 1..4 fill the FIFO; req_ready=0 at level 4; responses return in tag order 0..4.
- FPU never asserts done, TIMEOUT=16 -> rsp_valid rises 16 cycles after entering WAIT with rsp_z=7FC00000, rsp_flags=100.
- MUL 7F000000*7F000000 with model overflow=1, z=7F800000 -> rsp_flags=001, rsp_z=7F800000.
- rsp_ready held low 10 cycles with 2 queued jobs -> rsp_* stable, no new fpu_start, level stays 1.
- rst driven low mid-WAIT -> all outputs immediately at reset values (level=0, fpu_rst=1, rsp_valid=0); after release, idle=1 with no spurious response.
